// File: rtl/vecmac_pkg.sv
// Shared types and constants for the vector MAC front-end.
package vecmac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_SETTLE,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  localparam int OP_W        = 4;
  localparam int PROD_W      = 8;
  localparam int CNT_W       = 8;
  localparam int DEF_SETTLE  = 4;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_chain <= {STAGES{RST_VAL}};
    else          r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/mac_sequencer.sv
// Clocked sequencer for a self-timed 4x4 multiplier: issues operand pairs,
// waits out the Finish pulse, captures products and accumulates a dot product.
module mac_sequencer
  import vecmac_pkg::*;
#(
  parameter int FIN_SYNC = 2,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int ACC_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_last,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_o,
  input  logic              mul_finish,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t              r_state, w_next;
  logic [OP_W-1:0]     r_a, r_b;
  logic                r_last;
  logic [PROD_W-1:0]   r_prod;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic [TW-1:0]       r_tmo;
  logic [SW-1:0]       r_set;
  logic                r_seen_low;
  logic                w_fin;
  logic                w_busy;
  logic                w_tmo_hit;
  logic                w_settled;
  logic [ACC_W:0]      w_sum;

  // Resets high so a Finish left over from before reset is ignored until
  // it has been observed low through the whole chain.
  sync_bit #(.STAGES(FIN_SYNC), .RST_VAL(1'b1)) u_fin_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (mul_finish),
    .o_q     (w_fin)
  );

  assign w_busy    = (r_state == S_ISSUE) || (r_state == S_DRAIN) || (r_state == S_SETTLE);
  assign w_tmo_hit = w_busy && (r_tmo == TW'(TIMEOUT - 1));
  assign w_settled = (r_set == SW'(SETTLE - 1));
  assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(r_prod);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        // Only a rising Finish seen after a low one belongs to this multiply.
        if (w_tmo_hit)                w_next = S_ACCUM;
        else if (w_fin && r_seen_low) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        mul_start = 1'b1;
        if (w_tmo_hit)   w_next = S_ACCUM;
        else if (!w_fin) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_tmo_hit || w_settled) w_next = S_ACCUM;
      end
      S_ACCUM: w_next = r_last ? S_OUTPUT : S_IDLE;
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_last     <= 1'b0;
      r_prod     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_tmo      <= '0;
      r_set      <= '0;
      r_seen_low <= 1'b0;
    end else begin
      r_seen_low <= (r_state == S_ISSUE) && (r_seen_low || !w_fin);
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_last <= in_last;
            r_tmo  <= '0;
            r_set  <= '0;
          end
        end
        S_ISSUE, S_DRAIN, S_SETTLE: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_tmo_hit) begin
            r_prod <= '0;
            r_err  <= 1'b1;
          end else if (r_state == S_SETTLE) begin
            r_set <= r_set + 1'b1;
            // mul_o is asynchronous but has been static for SETTLE cycles.
            if (w_settled) r_prod <= mul_o;
          end
        end
        S_ACCUM: begin
          if (w_sum[ACC_W]) begin
            r_acc <= '1;
            r_err <= 1'b1;
          end else begin
            r_acc <= w_sum[ACC_W-1:0];
          end
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_a     = r_a;
  assign mul_b     = r_b;
  assign out_sum   = r_acc;
  assign out_count = r_cnt;
  assign out_err   = r_err;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: two instances (16-bit acc / 8-bit acc with short
// timeout), a behavioural self-timed multiplier each, and a dot-product model.
module tb_mac_sequencer;

  logic        clk;
  logic        reset_n;
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [3:0]  in_a       [2];
  logic [3:0]  in_b       [2];
  logic        in_last    [2];
  logic        mul_start  [2];
  logic [3:0]  mul_a      [2];
  logic [3:0]  mul_b      [2];
  logic [7:0]  mul_o      [2] = '{8'h00, 8'h00};
  logic        mul_finish [2] = '{1'b0, 1'b0};
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [7:0]  out_count  [2];
  logic        out_err    [2];
  logic [15:0] sum0;
  logic [7:0]  sum1;
  bit          hang       [2];

  int n_chk = 0;
  int n_err = 0;
  int n_pulse = 0;

  mac_sequencer #(.ACC_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .in_last(in_last[0]), .mul_start(mul_start[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_o(mul_o[0]), .mul_finish(mul_finish[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sum(sum0), .out_count(out_count[0]), .out_err(out_err[0])
  );

  mac_sequencer #(.ACC_W(8), .TIMEOUT(20)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .in_last(in_last[1]), .mul_start(mul_start[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_o(mul_o[1]), .mul_finish(mul_finish[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sum(sum1), .out_count(out_count[1]), .out_err(out_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Self-timed multiplier: Finish pulses ~1.2 cycles after start, product
  // becomes valid as Finish falls. A hung multiplier never answers.
  for (genvar g = 0; g < 2; g++) begin : g_mul
    always @(posedge mul_start[g]) begin
      if (!hang[g]) begin
        mul_o[g] = 8'hA5;
        #12;
        mul_finish[g] = 1'b1;
        #25;
        mul_o[g] = {4'b0, mul_a[g]} * {4'b0, mul_b[g]};
        mul_finish[g] = 1'b0;
      end
    end
  end

  always @(posedge mul_start[0]) n_pulse <= n_pulse + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Dot-product model: sum of products, timed-out elements count 0 and flag
  // err, the sum clips at the accumulator maximum and flags err when it does.
  int m_sum [2], m_cnt [2], m_err [2];
  int e_sum [2], e_cnt [2], e_err [2], e_ok [2];

  function automatic int maxv(input int g);
    return (g == 0) ? 65535 : 255;
  endfunction

  function automatic int elem(input int g);
    return hang[g] ? 0 : int'(in_a[g]) * int'(in_b[g]);
  endfunction

  function automatic int cinc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int g = 0; g < 2; g++) begin
        m_sum[g] <= 0; m_cnt[g] <= 0; m_err[g] <= 0; e_ok[g] <= 0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (in_valid[g] && in_ready[g]) begin
          if (in_last[g]) begin
            e_sum[g] <= (m_sum[g] + elem(g) > maxv(g)) ? maxv(g) : m_sum[g] + elem(g);
            e_cnt[g] <= cinc(m_cnt[g]);
            e_err[g] <= (m_err[g] != 0 || hang[g] || m_sum[g] + elem(g) > maxv(g)) ? 1 : 0;
            e_ok[g]  <= 1;
            m_sum[g] <= 0; m_cnt[g] <= 0; m_err[g] <= 0;
          end else begin
            m_sum[g] <= m_sum[g] + elem(g);
            m_cnt[g] <= cinc(m_cnt[g]);
            m_err[g] <= (m_err[g] != 0 || hang[g]) ? 1 : 0;
          end
        end
        if (out_valid[g] && out_ready[g]) e_ok[g] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      for (int g = 0; g < 2; g++) begin
        chk("idle_no_start", {31'b0, in_ready[g] & mul_start[g]}, 0);
        if (out_valid[g]) begin
          chk("out_expected", e_ok[g], 1);
          chk("out_sum", (g == 0) ? {16'b0, sum0} : {24'b0, sum1}, e_sum[g]);
          chk("out_count", {24'b0, out_count[g]}, e_cnt[g]);
          chk("out_err", {31'b0, out_err[g]}, e_err[g]);
        end
      end
    end
  end

  task automatic send(input int g, input int a, input int b, input bit last);
    int n = 0;
    in_valid[g] = 1'b1; in_a[g] = 4'(a); in_b[g] = 4'(b); in_last[g] = last;
    while (!in_ready[g] && n < 1000) begin @(negedge clk); n++; end
    chk("accept_wait", {31'b0, in_ready[g]}, 1);
    @(negedge clk);
    in_valid[g] = 1'b0;
  endtask

  task automatic take(input int g, input int hold, output int s, output int c, output int e);
    int n = 0;
    while (!out_valid[g] && n < 2000) begin @(negedge clk); n++; end
    chk("sum_wait", {31'b0, out_valid[g]}, 1);
    repeat (hold) @(negedge clk);
    s = (g == 0) ? int'(sum0) : int'(sum1);
    c = int'(out_count[g]);
    e = int'(out_err[g]);
    out_ready[g] = 1'b1;
    @(negedge clk);
    out_ready[g] = 1'b0;
    chk("post_ack_valid", {31'b0, out_valid[g]}, 0);
    chk("post_ack_sum", (g == 0) ? {16'b0, sum0} : {24'b0, sum1}, 0);
    chk("post_ack_count", {24'b0, out_count[g]}, 0);
  endtask

  task automatic chk_reset_state(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk({nm, "_start"}, {31'b0, mul_start[g]}, 0);
      chk({nm, "_ready"}, {31'b0, in_ready[g]}, 1);
      chk({nm, "_valid"}, {31'b0, out_valid[g]}, 0);
      chk({nm, "_count"}, {24'b0, out_count[g]}, 0);
      chk({nm, "_err"}, {31'b0, out_err[g]}, 0);
      chk({nm, "_mula"}, {28'b0, mul_a[g]}, 0);
      chk({nm, "_mulb"}, {28'b0, mul_b[g]}, 0);
    end
    chk({nm, "_sum0"}, {16'b0, sum0}, 0);
    chk({nm, "_sum1"}, {24'b0, sum1}, 0);
  endtask

  initial begin
    int s, c, e, n, p0;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0; in_a[g] = '0; in_b[g] = '0; in_last[g] = 1'b0;
      out_ready[g] = 1'b0; hang[g] = 1'b0;
    end
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_reset_state("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // single element
    send(0, 3, 5, 1);
    take(0, 0, s, c, e);
    chk("t1_sum", s, 15); chk("t1_cnt", c, 1); chk("t1_err", e, 0);

    // four maximal elements, consumer stalls 10 cycles
    for (int i = 0; i < 4; i++) send(0, 15, 15, i == 3);
    take(0, 10, s, c, e);
    chk("t2_sum", s, 900); chk("t2_cnt", c, 4); chk("t2_err", e, 0);

    // zero operands and one start pulse per element
    p0 = n_pulse;
    send(0, 0, 7, 0); send(0, 7, 0, 0); send(0, 1, 1, 1);
    take(0, 0, s, c, e);
    chk("t3_sum", s, 1); chk("t3_cnt", c, 3);
    chk("t3_pulses", n_pulse - p0, 3);

    // 8-bit accumulator saturation
    send(1, 15, 15, 0); send(1, 15, 15, 1);
    take(1, 0, s, c, e);
    chk("t4_sum", s, 255); chk("t4_cnt", c, 2); chk("t4_err", e, 1);

    // hung multiplier: start must drop after exactly TIMEOUT cycles
    hang[1] = 1'b1;
    send(1, 2, 2, 0);
    n = 0;
    while (mul_start[1] && n < 100) begin n++; @(negedge clk); end
    chk("t5_start_cycles", n, 20);
    hang[1] = 1'b0;
    send(1, 3, 3, 1);
    take(1, 0, s, c, e);
    chk("t5_sum", s, 9); chk("t5_cnt", c, 2); chk("t5_err", e, 1);

    // reset while draining a multiply
    send(0, 5, 5, 0);
    n = 0;
    while (!in_ready[0] && n < 200) begin @(negedge clk); n++; end
    chk("t6_partial", {16'b0, sum0}, 25);
    send(0, 4, 4, 1);
    n = 0;
    while (!mul_finish[0] && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("t6_pre_start", {31'b0, mul_start[0]}, 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_state("t6_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send(0, 2, 3, 1);
    take(0, 0, s, c, e);
    chk("t6_sum", s, 6); chk("t6_cnt", c, 1); chk("t6_err", e, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
